// File: rtl/led_rgb_fade_seq_if.sv
// IO bus between the fade sequencer (master) and the RGB LED peripheral (slave).
interface led_rgb_fade_seq_if;
  logic [15:0] AIoAddr;
  logic [63:0] AIoMosi;
  logic [3:0]  AIoWrSize;
  logic [3:0]  AIoRdSize;
  logic        AIoAddrAck;

  modport master (
    output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
    input  AIoAddrAck
  );

  modport slave (
    input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
    output AIoAddrAck
  );
endinterface

// File: rtl/led_rgb_fade_seq.sv
// Frame-tick sequencer: resets the LED index, then writes a triangle-faded
// copy of the base colour to every LED with a per-LED phase offset.
module led_rgb_fade_seq #(
  parameter logic [15:0] CAddrBase   = 16'h0000,
  parameter int unsigned CLedCnt     = 16,
  parameter logic [23:0] CFrameDiv   = 24'd100000,
  parameter logic [7:0]  CStep       = 8'h04,
  parameter logic [7:0]  CPhaseOfs   = 8'h10,
  parameter logic [7:0]  CAckTimeout = 8'd32
) (
  input  logic                     AClkH,
  input  logic                     AResetH,
  input  logic                     AClkHEn,
  input  logic                     AEnable,
  input  logic [23:0]              ABaseColor,
  led_rgb_fade_seq_if.master       io,
  output logic                     ABusy,
  output logic                     AOverrun,
  output logic                     AErr,
  input  logic                     AErrClr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RSTIDX,
    S_WRLED,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_div;
  logic [7:0]  r_phase;
  logic [4:0]  r_idx;
  logic [7:0]  r_to;
  logic [23:0] r_base;
  logic        r_ovr;
  logic        r_err;

  logic        w_tick;
  logic        w_ack;
  logic        w_to_hit;
  logic        w_busy;
  logic        w_start;
  logic        w_timeout;
  logic [7:0]  w_q;
  logic [7:0]  w_lvl;
  logic [15:0] w_pr_r;
  logic [15:0] w_pr_g;
  logic [15:0] w_pr_b;
  logic [23:0] w_color;

  assign w_tick   = AClkHEn & AEnable & (r_div == (CFrameDiv - 24'd1));
  assign w_ack    = AClkHEn & io.AIoAddrAck;
  assign w_to_hit = (r_to == (CAckTimeout - 8'd1));

  // Triangle brightness: ramps up over q[6:0] in the low half, down in the high half.
  assign w_q     = r_phase + (8'(r_idx) * CPhaseOfs);
  assign w_lvl   = w_q[7] ? ~{w_q[6:0], 1'b0} : {w_q[6:0], 1'b0};
  assign w_pr_r  = {8'h00, r_base[23:16]} * {8'h00, w_lvl};
  assign w_pr_g  = {8'h00, r_base[15:8]}  * {8'h00, w_lvl};
  assign w_pr_b  = {8'h00, r_base[7:0]}   * {8'h00, w_lvl};
  assign w_color = {w_pr_r[15:8], w_pr_g[15:8], w_pr_b[15:8]};

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_state <= S_IDLE;
    end else if (AClkHEn) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    io.AIoAddr      = '0;
    io.AIoMosi      = '0;
    io.AIoWrSize    = '0;
    io.AIoRdSize    = '0;
    w_busy          = 1'b0;
    w_start         = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_start     = 1'b1;
          w_state_nxt = S_RSTIDX;
        end
      end
      S_RSTIDX: begin
        w_busy       = 1'b1;
        io.AIoAddr   = CAddrBase;
        io.AIoRdSize = 4'b0001;
        if (w_ack) begin
          w_state_nxt = S_WRLED;
        end else if (AClkHEn && w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WRLED: begin
        w_busy       = 1'b1;
        io.AIoAddr   = CAddrBase;
        io.AIoWrSize = 4'b0100;
        io.AIoMosi   = {40'h0, w_color};
        if (w_ack) begin
          if (r_idx == 5'(CLedCnt - 1)) begin
            w_state_nxt = S_DONE;
          end
        end else if (AClkHEn && w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_div   <= '0;
      r_phase <= '0;
      r_idx   <= '0;
      r_to    <= '0;
      r_base  <= '0;
      r_ovr   <= 1'b0;
      r_err   <= 1'b0;
    end else if (AClkHEn) begin
      if (!AEnable || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 24'd1;
      end

      if (w_start) begin
        r_base <= ABaseColor;
        r_idx  <= '0;
      end else if (r_state == S_WRLED && w_ack) begin
        r_idx <= r_idx + 5'd1;
      end

      // Each accepted transaction restarts the ack watchdog for the next one.
      if (w_start || w_ack || w_timeout) begin
        r_to <= '0;
      end else if (w_busy) begin
        r_to <= r_to + 8'd1;
      end

      if (r_state == S_DONE) begin
        r_phase <= r_phase + CStep;
      end

      if (w_tick && w_busy) begin
        r_ovr <= 1'b1;
      end else if (AErrClr) begin
        r_ovr <= 1'b0;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (AErrClr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign ABusy    = w_busy;
  assign AOverrun = r_ovr;
  assign AErr     = r_err;

endmodule

// File: doc/led_rgb_fade_seq.md
Name: led_rgb_fade_seq

Overview:
- Bus-master sequencer that drives the 16-LED RGB PWM peripheral through its IO slave port.
- On every frame tick it resets the peripheral's LED index, then writes a fresh 24-bit colour to each LED in turn.
- Each LED's colour is the base colour scaled by a triangle-wave brightness, with a per-LED phase offset, giving a running "breathing" pattern.
- Sits between the system tick domain logic and the LED peripheral's IO port, replacing CPU-driven colour writes.

Parameters:
- CAddrBase, 16'h0000: IO base address of the LED peripheral.
- CLedCnt, 16: LEDs per frame, range 1..16.
- CFrameDiv, 24'd100000: enabled clocks per frame tick, must be ≥ 2.
- CStep, 8'h04: phase increment per frame.
- CPhaseOfs, 8'h10: phase offset between adjacent LEDs.
- CAckTimeout, 8'd32: enabled cycles allowed for a slave ack before an error.

Ports:
- AClkH, input, 1: clock.
- AResetH, input, 1: synchronous reset, active-high.
- AClkHEn, input, 1: clock enable; all state advances only when it is 1.
- AEnable, input, 1: run sequencer.
- ABaseColor, input, 24: {R,G,B} base colour, sampled at frame start.
- AIoAddr, output, 16: IO address.
- AIoMosi, output, 64: write data.
- AIoWrSize, output, 4: one-hot write size {Q,D,W,B}.
- AIoRdSize, output, 4: one-hot read size {Q,D,W,B}.
- AIoAddrAck, input, 1: slave accept.
- ABusy, output, 1: frame in progress.
- AOverrun, output, 1: sticky; a tick arrived while busy.
- AErr, output, 1: sticky; ack timeout occurred.
- AErrClr, input, 1: clears AOverrun and AErr.

Behaviour:
- Reset (AResetH=1 at a clock edge, regardless of AClkHEn):
  - State IDLE; frame divider, phase P, LED counter and timeout counter all 0.
  - All outputs 0.
  - Reset mid-transaction aborts the transaction with no further bus activity.
- Frame divider:
  - Counts enabled cycles 0..CFrameDiv-1 and pulses tick for one enabled cycle at wrap.
  - Runs only while AEnable=1; it is cleared while AEnable=0.
- States: IDLE, RSTIDX, WRLED, DONE.
- IDLE:
  - On tick with AEnable=1: latch ABaseColor into FBase, LED counter i=0, ABusy=1, go to RSTIDX.
- RSTIDX:
  - Drive AIoAddr=CAddrBase, AIoRdSize=4'b0001, AIoWrSize=0.
  - Hold until AIoAddrAck=1 in an enabled cycle; then go to WRLED.
- WRLED:
  - Drive AIoAddr=CAddrBase, AIoWrSize=4'b0100 (dword), AIoMosi={40'h0, Ci}.
  - On ack: i+1. If i+1==CLedCnt go to DONE, otherwise stay in WRLED; the next LED's data is presented in the following cycle with no idle gap.
- DONE:
  - P ← P+CStep (8-bit wrap), ABusy=0, all bus outputs 0, go to IDLE next enabled cycle.
- Colour arithmetic, computed combinationally from registered i, P and FBase:
  - q = P + i·CPhaseOfs, mod 256.
  - L = q[7] ? ~{q[6:0],1'b0} : {q[6:0],1'b0}. Examples: q=0→0, 0x40→0x80, 0x7F→0xFE, 0x80→0xFF, 0xFF→0x01.
  - Each channel out = (ch·L)>>8, an 8×8 multiply truncated to the upper 8 bits.
  - Ci = {Rout, Gout, Bout}.
- Bus rules:
  - Address and sizes are stable from issue until ack.
  - Sizes are 0 whenever not in RSTIDX or WRLED.
  - At most one of AIoWrSize or AIoRdSize is non-zero at any time.
- Timeout:
  - The counter resets on each new transaction and increments on each enabled cycle without ack.
  - On reaching CAckTimeout: set AErr, zero the bus outputs, ABusy=0, go to IDLE. P is not advanced.
- Overrun:
  - A tick while ABusy=1 is dropped and sets AOverrun.
- AEnable deassert mid-frame: the current frame completes; no new frame starts.
- AErrClr:
  - Clears both sticky flags.
  - If a set event occurs in the same cycle as AErrClr, the set wins.
- AClkHEn=0: every register holds, and ack is ignored.

Test Plan:
- Reset, then AEnable=1, CFrameDiv=4, ack tied high → first tick: one byte read at 16'h0000, then 16 back-to-back dword writes, ABusy high for exactly 17 cycles.
- ABaseColor=24'hFF8040, P=0, CPhaseOfs=0x10 → LED0 data 0, LED4 (q=0x40, L=0x80) data 24'h7F4020, LED8 (L=0xFF) data 24'hFE7F3F.
- Ack withheld for 3 cycles during LED5's write → address and data held stable; exactly 16 writes total; LED6 data follows ack.
- Ack never asserted in RSTIDX → after 32 cycles AErr=1, bus outputs 0, ABusy=0, P unchanged; AErrClr → AErr=0.
- CFrameDiv=8 with ack delayed 10 cycles per transaction → AOverrun=1, frame completes normally, P advances by CStep once.
- AResetH pulsed during WRLED at LED3 → next cycle: sizes 0, ABusy=0; after release, no bus activity until the next tick.
